// File: rtl/uart_wb_pkg.sv
// Shared definitions for the Wishbone UART controller: register offsets,
// STAT/CTRL bit positions and the transmit launch FSM state encoding.
package uart_wb_pkg;

  // Register offsets within the 16-byte window.
  localparam logic [3:0] RX_DATA_OFS = 4'h0;
  localparam logic [3:0] TX_DATA_OFS = 4'h4;
  localparam logic [3:0] STAT_OFS    = 4'h8;
  localparam logic [3:0] CTRL_OFS    = 4'hC;

  // STAT bit positions.
  localparam int STAT_RX_EMPTY   = 0;
  localparam int STAT_RX_FULL    = 1;
  localparam int STAT_TX_EMPTY   = 2;
  localparam int STAT_TX_FULL    = 3;
  localparam int STAT_RX_OVR     = 4;
  localparam int STAT_FRAME_ERR  = 5;
  localparam int STAT_TX_OVF     = 6;
  localparam int STAT_TX_ACTIVE  = 7;
  localparam int STAT_RX_LVL_LSB = 8;
  localparam int STAT_TX_LVL_LSB = 16;

  // CTRL bit positions.
  localparam int CTRL_RX_IRQ_EN  = 0;
  localparam int CTRL_TXE_IRQ_EN = 1;
  localparam int CTRL_ERR_IRQ_EN = 2;
  localparam int CTRL_ECHO       = 3;

  // Transmit launch FSM states.
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD    = 3'd1,
    START   = 3'd2,
    WAIT_HI = 3'd3,
    WAIT_LO = 3'd4
  } tx_state_e;

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous FIFO with registered read data: rdata is updated on the
// clock edge that consumes rd_en and is valid the following cycle.
// DEPTH must be a power of two so the pointers wrap naturally.
module uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [LW-1:0]    level_r;
  logic [WIDTH-1:0] rdata_r;
  logic             push_s;
  logic             pop_s;

  // A write to a full FIFO and a read from an empty FIFO are ignored.
  assign full   = (level_r == LW'(DEPTH));
  assign empty  = (level_r == LW'(0));
  assign push_s = wr_en && !full;
  assign pop_s  = rd_en && !empty;
  assign level  = level_r;
  assign rdata  = rdata_r;

  // Storage array; contents need no reset because level gates every read.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= wdata;
    end
  end

  // Pointers, occupancy and the registered read port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= AW'(0);
      rd_ptr_r <= AW'(0);
      level_r  <= LW'(0);
      rdata_r  <= WIDTH'(0);
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
        rdata_r  <= mem_r[rd_ptr_r];
      end
      case ({push_s, pop_s})
        2'b10:   level_r <= level_r + LW'(1);
        2'b01:   level_r <= level_r - LW'(1);
        default: level_r <= level_r;
      endcase
    end
  end

endmodule

// File: rtl/uart_wb_ctrl.sv
// Wishbone-mapped UART controller: RX/TX FIFOs, four-register CPU map,
// transmit launch FSM, sticky error flags and a maskable level interrupt.
// Optional receive echo is built when UART_WB_CTRL_ECHO_EN is defined.
module uart_wb_ctrl
  import uart_wb_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter int          DATA_W    = 8,
  parameter int          RX_DEPTH  = 16,
  parameter int          TX_DEPTH  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_wb_valid,
  input  logic [31:0]       i_wb_adr,
  input  logic              i_wb_we,
  input  logic [31:0]       i_wb_dat,
  input  logic [3:0]        i_wb_sel,
  output logic              o_wb_ack,
  output logic [31:0]       o_wb_dat,
  input  logic [DATA_W-1:0] i_rx_data,
  input  logic              i_rx_done,
  input  logic              i_rx_frame_err,
  output logic [DATA_W-1:0] o_tx_data,
  output logic              o_tx_start,
  input  logic              i_tx_busy,
  output logic              o_irq
);

`ifdef UART_WB_CTRL_ECHO_EN
  localparam logic [3:0] CTRL_WMASK = 4'hF;
`else
  localparam logic [3:0] CTRL_WMASK = 4'h7;
`endif

  logic                      ack_r, rx_rd_r, tx_start_r, irq_r;
  logic [31:0]               wb_dat_r, rd_dat_s, stat_s;
  logic [DATA_W-1:0]         tx_data_r, rx_rdata_s, tx_rdata_s, tx_wdata_s;
  logic [3:0]                ctrl_r;
  logic [2:0]                sticky_r, sticky_set_s, sticky_clr_s;
  tx_state_e                 state_r, state_next_s;
  logic                      access_s, hit_s;
  logic [3:0]                ofs_s;
  logic                      rx_pop_s, cpu_tx_wr_s, stat_wr_s, ctrl_wr_s;
  logic                      rx_good_s, rx_ferr_s, echo_push_s, tx_wr_s, tx_pop_s;
  logic                      rx_full_s, rx_empty_s, tx_full_s, tx_empty_s, tx_active_s;
  logic [$clog2(RX_DEPTH):0] rx_level_s;
  logic [$clog2(TX_DEPTH):0] tx_level_s;
  logic                      unused_s;

  assign unused_s = ^{i_wb_dat, i_wb_sel};

  // One access per valid; the ack flop blocks a second access next cycle.
  assign access_s  = i_wb_valid && !ack_r;
  assign hit_s     = (i_wb_adr[31:4] == BASE_ADDR[31:4]);
  assign ofs_s     = i_wb_adr[3:0];
  assign rx_good_s = i_rx_done && !i_rx_frame_err;
  assign rx_ferr_s = i_rx_done && i_rx_frame_err;
  assign tx_active_s = (state_r != IDLE);

`ifdef UART_WB_CTRL_ECHO_EN
  assign echo_push_s = rx_good_s && ctrl_r[CTRL_ECHO];
`else
  assign echo_push_s = 1'b0;
`endif

  // Echo owns the TX write port when it collides with a CPU write.
  assign tx_wr_s    = echo_push_s || cpu_tx_wr_s;
  assign tx_wdata_s = echo_push_s ? i_rx_data : i_wb_dat[DATA_W-1:0];
  assign sticky_set_s = {(tx_wr_s && tx_full_s) || (echo_push_s && cpu_tx_wr_s),
                         rx_ferr_s,
                         rx_good_s && rx_full_s};
  assign sticky_clr_s = stat_wr_s ? i_wb_dat[6:4] : 3'b000;

  uart_sync_fifo #(.WIDTH(DATA_W), .DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk(clk), .rst_n(rst_n), .wr_en(rx_good_s), .wdata(i_rx_data),
    .rd_en(rx_pop_s), .rdata(rx_rdata_s), .full(rx_full_s),
    .empty(rx_empty_s), .level(rx_level_s)
  );

  uart_sync_fifo #(.WIDTH(DATA_W), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk(clk), .rst_n(rst_n), .wr_en(tx_wr_s), .wdata(tx_wdata_s),
    .rd_en(tx_pop_s), .rdata(tx_rdata_s), .full(tx_full_s),
    .empty(tx_empty_s), .level(tx_level_s)
  );

  // Decode the accessed register into single-cycle side-effect strobes.
  always_comb begin
    rx_pop_s    = 1'b0;
    cpu_tx_wr_s = 1'b0;
    stat_wr_s   = 1'b0;
    ctrl_wr_s   = 1'b0;
    if (access_s && hit_s) begin
      case (ofs_s)
        RX_DATA_OFS: rx_pop_s    = !i_wb_we && !rx_empty_s;
        TX_DATA_OFS: cpu_tx_wr_s = i_wb_we && i_wb_sel[0];
        STAT_OFS:    stat_wr_s   = i_wb_we;
        CTRL_OFS:    ctrl_wr_s   = i_wb_we;
        default:     rx_pop_s    = 1'b0;
      endcase
    end else begin
      rx_pop_s = 1'b0;
    end
  end

  // Assemble the STAT word from FIFO flags, sticky errors and levels.
  always_comb begin
    stat_s = 32'h0000_0000;
    stat_s[STAT_RX_EMPTY]  = rx_empty_s;
    stat_s[STAT_RX_FULL]   = rx_full_s;
    stat_s[STAT_TX_EMPTY]  = tx_empty_s;
    stat_s[STAT_TX_FULL]   = tx_full_s;
    stat_s[STAT_TX_OVF:STAT_RX_OVR] = sticky_r;
    stat_s[STAT_TX_ACTIVE] = tx_active_s;
    stat_s[STAT_RX_LVL_LSB +: 8] = 8'(rx_level_s);
    stat_s[STAT_TX_LVL_LSB +: 8] = 8'(tx_level_s);
  end

  // Read mux for the registers that are not FIFO-backed.
  always_comb begin
    rd_dat_s = 32'h0000_0000;
    if (access_s && hit_s && !i_wb_we) begin
      case (ofs_s)
        STAT_OFS: rd_dat_s = stat_s;
        CTRL_OFS: rd_dat_s = {28'h000_0000, ctrl_r};
        default:  rd_dat_s = 32'h0000_0000;
      endcase
    end else begin
      rd_dat_s = 32'h0000_0000;
    end
  end

  // Bus response: ack, captured read data and RX-pop marker.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack_r    <= 1'b0;
      wb_dat_r <= 32'h0000_0000;
      rx_rd_r  <= 1'b0;
    end else begin
      ack_r    <= access_s;
      wb_dat_r <= rd_dat_s;
      rx_rd_r  <= rx_pop_s;
    end
  end

  // RX FIFO data lands in its own register on the ack edge, so select it then.
  assign o_wb_ack = ack_r;
  assign o_wb_dat = rx_rd_r ? 32'(rx_rdata_s) : wb_dat_r;

  // Control register and sticky flags; a set in the same cycle beats a clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_r   <= 4'h0;
      sticky_r <= 3'b000;
    end else begin
      if (ctrl_wr_s) begin
        ctrl_r <= i_wb_dat[3:0] & CTRL_WMASK;
      end
      sticky_r <= (sticky_r & ~sticky_clr_s) | sticky_set_s;
    end
  end

  // Launch FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Launch FSM transitions; IDLE pops so the character is ready in LOAD.
  always_comb begin
    state_next_s = state_r;
    tx_pop_s     = 1'b0;
    case (state_r)
      IDLE: begin
        if (!tx_empty_s && !i_tx_busy) begin
          tx_pop_s     = 1'b1;
          state_next_s = LOAD;
        end else begin
          state_next_s = IDLE;
        end
      end
      LOAD:    state_next_s = START;
      START:   state_next_s = WAIT_HI;
      WAIT_HI: begin
        if (i_tx_busy) begin
          state_next_s = WAIT_LO;
        end else begin
          state_next_s = WAIT_HI;
        end
      end
      WAIT_LO: begin
        if (!i_tx_busy) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = WAIT_LO;
        end
      end
      default: state_next_s = IDLE;
    endcase
  end

  // Registered serialiser outputs and interrupt.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_data_r  <= DATA_W'(0);
      tx_start_r <= 1'b0;
      irq_r      <= 1'b0;
    end else begin
      if (state_r == LOAD) begin
        tx_data_r <= tx_rdata_s;
      end
      tx_start_r <= (state_next_s == START);
      irq_r      <= (ctrl_r[CTRL_RX_IRQ_EN] && !rx_empty_s) ||
                    (ctrl_r[CTRL_TXE_IRQ_EN] && tx_empty_s && !tx_active_s) ||
                    (ctrl_r[CTRL_ERR_IRQ_EN] && (sticky_r != 3'b000));
    end
  end

  assign o_tx_data  = tx_data_r;
  assign o_tx_start = tx_start_r;
  assign o_irq      = irq_r;

endmodule

// File: tb/tb_uart_wb_ctrl.sv
// Self-checking bench for uart_wb_ctrl with a queue-based reference model.
module tb_uart_wb_ctrl;

  localparam logic [31:0] BASE = 32'h3000_0000;
  localparam int RXD = 16;
  localparam int TXD = 16;
`ifdef UART_WB_CTRL_ECHO_EN
  localparam logic [3:0] CTRL_MASK = 4'hF;
`else
  localparam logic [3:0] CTRL_MASK = 4'h7;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_wb_valid, i_wb_we;
  logic [31:0] i_wb_adr, i_wb_dat;
  logic [3:0]  i_wb_sel;
  logic        o_wb_ack;
  logic [31:0] o_wb_dat;
  logic [7:0]  i_rx_data;
  logic        i_rx_done, i_rx_frame_err;
  logic [7:0]  o_tx_data;
  logic        o_tx_start, i_tx_busy, o_irq;
  logic        hold_busy, ser_busy;

  int checks = 0;
  int errors = 0;
  int starts = 0;
  logic [7:0]  rx_q[$];
  logic [7:0]  tx_q[$];
  logic [2:0]  m_sticky;
  logic [3:0]  m_ctrl;
  logic [31:0] d, exp_v;
  logic [7:0]  b;

  assign i_tx_busy = hold_busy | ser_busy;

  always #5 clk = ~clk;

  uart_wb_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .i_wb_valid(i_wb_valid), .i_wb_adr(i_wb_adr), .i_wb_we(i_wb_we),
    .i_wb_dat(i_wb_dat), .i_wb_sel(i_wb_sel),
    .o_wb_ack(o_wb_ack), .o_wb_dat(o_wb_dat),
    .i_rx_data(i_rx_data), .i_rx_done(i_rx_done), .i_rx_frame_err(i_rx_frame_err),
    .o_tx_data(o_tx_data), .o_tx_start(o_tx_start), .i_tx_busy(i_tx_busy),
    .o_irq(o_irq)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Expected STAT while the transmitter is idle.
  function automatic logic [31:0] model_stat();
    logic [31:0] s;
    s = 32'h0;
    s[0] = (rx_q.size() == 0);
    s[1] = (rx_q.size() == RXD);
    s[2] = (tx_q.size() == 0);
    s[3] = (tx_q.size() == TXD);
    s[6:4] = m_sticky;
    s = s + (32'(rx_q.size()) << 8) + (32'(tx_q.size()) << 16);
    return s;
  endfunction

  function automatic logic [31:0] model_irq();
    return 32'((m_ctrl[0] && rx_q.size() != 0) || (m_ctrl[1] && tx_q.size() == 0) ||
               (m_ctrl[2] && m_sticky != 3'b000));
  endfunction

  task automatic wb_xfer(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                         output logic [31:0] rd);
    bit got = 0;
    i_wb_valid = 1'b1; i_wb_we = we; i_wb_adr = adr; i_wb_dat = dat; i_wb_sel = 4'hF;
    for (int n = 0; n < 8 && !got; n++) begin
      @(posedge clk); #1;
      if (o_wb_ack) got = 1;
    end
    if (!got) check_val("wb_ack_timeout", 32'd0, 32'd1);
    rd = o_wb_dat;
    i_wb_valid = 1'b0; i_wb_we = 1'b0;
    @(posedge clk); #1;
    check_val("wb_ack_single", 32'(o_wb_ack), 32'd0);
  endtask

  task automatic check_stat(input string tag);
    logic [31:0] r;
    wb_xfer(1'b0, BASE + 32'h8, 32'h0, r);
    check_val(tag, r, model_stat());
  endtask

  task automatic write_stat(input logic [31:0] v);
    logic [31:0] r;
    wb_xfer(1'b1, BASE + 32'h8, v, r);
    m_sticky = m_sticky & ~v[6:4];
  endtask

  task automatic write_ctrl(input logic [31:0] v);
    logic [31:0] r;
    wb_xfer(1'b1, BASE + 32'hC, v, r);
    m_ctrl = v[3:0] & CTRL_MASK;
  endtask

  task automatic cpu_tx(input logic [7:0] v);
    logic [31:0] r;
    wb_xfer(1'b1, BASE + 32'h4, {24'h0, v}, r);
    if (tx_q.size() == TXD) m_sticky[2] = 1'b1;
    else tx_q.push_back(v);
  endtask

  task automatic rx_read(input string tag);
    logic [31:0] r, e;
    wb_xfer(1'b0, BASE, 32'h0, r);
    e = (rx_q.size() != 0) ? 32'(rx_q.pop_front()) : 32'h0;
    check_val(tag, r, e);
  endtask

  task automatic rx_send(input logic [7:0] v, input logic ferr);
    i_rx_data = v; i_rx_frame_err = ferr; i_rx_done = 1'b1;
    @(posedge clk); #1;
    i_rx_done = 1'b0; i_rx_frame_err = 1'b0;
    if (ferr) m_sticky[1] = 1'b1;
    else begin
      if (rx_q.size() == RXD) m_sticky[0] = 1'b1;
      else rx_q.push_back(v);
      if (m_ctrl[3]) begin
        if (tx_q.size() == TXD) m_sticky[2] = 1'b1;
        else tx_q.push_back(v);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic wait_tx_idle();
    bit done = 0;
    for (int n = 0; n < 3000 && !done; n++) begin
      if (tx_q.size() == 0 && !ser_busy && !hold_busy) done = 1;
      else begin @(posedge clk); #1; end
    end
    if (!done) check_val("tx_drain_timeout", 32'd0, 32'd1);
    repeat (3) begin @(posedge clk); #1; end
  endtask

  // Serialiser model: busy for ten cycles after each launch pulse.
  initial begin
    logic [31:0] e;
    ser_busy = 1'b0;
    forever begin
      @(posedge clk); #2;
      if (o_tx_start === 1'b1) begin
        starts++;
        check_val("tx_start_while_busy", 32'(i_tx_busy), 32'd0);
        e = (tx_q.size() != 0) ? 32'(tx_q.pop_front()) : 32'hFFFF_FFFF;
        check_val("tx_data", 32'(o_tx_data), e);
        ser_busy = 1'b1;
        @(posedge clk); #2;
        check_val("tx_start_pulse", 32'(o_tx_start), 32'd0);
        repeat (9) @(posedge clk);
        #2;
        ser_busy = 1'b0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; hold_busy = 1'b0;
    i_wb_valid = 1'b0; i_wb_we = 1'b0; i_wb_adr = 32'h0; i_wb_dat = 32'h0; i_wb_sel = 4'h0;
    i_rx_data = 8'h0; i_rx_done = 1'b0; i_rx_frame_err = 1'b0;
    m_sticky = 3'b000; m_ctrl = 4'h0;
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_ack", 32'(o_wb_ack), 32'd0);
    check_val("rst_dat", o_wb_dat, 32'h0);
    check_val("rst_tx_data", 32'(o_tx_data), 32'h0);
    check_val("rst_tx_start", 32'(o_tx_start), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Reset state through the register map.
    wb_xfer(1'b0, BASE + 32'h8, 32'h0, d);
    check_val("reset_stat", d, 32'h0000_0005);
    check_val("reset_irq", 32'(o_irq), 32'd0);
    wb_xfer(1'b0, BASE + 32'hC, 32'h0, d);
    check_val("reset_ctrl", d, 32'h0);

    // Three characters through the launch FSM.
    cpu_tx(8'h41); cpu_tx(8'h42); cpu_tx(8'h43);
    wait_tx_idle();
    check_val("tx_start_count", 32'(starts), 32'd3);
    check_stat("stat_after_tx");

    // RX overrun at depth, ordered drain, empty read, W1C.
    for (int i = 0; i < 17; i++) rx_send(8'(i), 1'b0);
    check_stat("stat_rx_full");
    for (int i = 0; i < 16; i++) rx_read("rx_drain");
    rx_read("rx_empty_read");
    write_stat(32'h10);
    check_stat("stat_rx_ovr_clr");

    // Frame error: discarded, flag set, irq one cycle later.
    write_ctrl(32'h4);
    check_val("irq_err_idle", 32'(o_irq), model_irq());
    i_rx_data = 8'h55; i_rx_frame_err = 1'b1; i_rx_done = 1'b1;
    @(posedge clk); #1;
    i_rx_done = 1'b0; i_rx_frame_err = 1'b0;
    m_sticky[1] = 1'b1;
    check_val("irq_lag", 32'(o_irq), 32'd0);
    @(posedge clk); #1;
    check_val("irq_err", 32'(o_irq), 32'd1);
    check_stat("stat_frame_err");
    write_stat(32'h70);
    write_ctrl(32'h0);

    // Valid held three cycles on STAT: ack 0,1,0,1 with two reads.
    i_wb_valid = 1'b1; i_wb_we = 1'b0; i_wb_adr = BASE + 32'h8; i_wb_sel = 4'hF;
    check_val("b2b_ack0", 32'(o_wb_ack), 32'd0);
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk); #1;
      check_val("b2b_ack", 32'(o_wb_ack), 32'(k % 2));
      if (o_wb_ack) check_val("b2b_dat", o_wb_dat, model_stat());
    end
    i_wb_valid = 1'b0;
    @(posedge clk); #1;
    check_val("b2b_ack_end", 32'(o_wb_ack), 32'd0);

    // RX pop coinciding with a hardware push at level 3.
    for (int i = 0; i < 3; i++) rx_send(8'($urandom_range(0, 255)), 1'b0);
    b = 8'($urandom_range(0, 255));
    i_wb_valid = 1'b1; i_wb_we = 1'b0; i_wb_adr = BASE;
    i_rx_data = b; i_rx_done = 1'b1;
    @(posedge clk); #1;
    i_wb_valid = 1'b0; i_rx_done = 1'b0;
    check_val("coinc_ack", 32'(o_wb_ack), 32'd1);
    exp_v = 32'(rx_q.pop_front());
    rx_q.push_back(b);
    check_val("coinc_dat", o_wb_dat, exp_v);
    @(posedge clk); #1;
    check_stat("stat_coinc_level3");
    for (int i = 0; i < 3; i++) rx_read("coinc_drain");

    // TX overflow while the serialiser is held busy, then drain.
    hold_busy = 1'b1;
    for (int i = 0; i < 17; i++) cpu_tx(8'($urandom_range(0, 255)));
    check_stat("stat_tx_full");
    hold_busy = 1'b0;
    wait_tx_idle();
    check_val("tx_start_count2", 32'(starts), 32'd19);
    write_stat(32'h40);
    check_stat("stat_tx_ovf_clr");

    // Unmapped addresses and CTRL read-back.
    wb_xfer(1'b0, BASE + 32'h10, 32'h0, d);
    check_val("unmapped_rd", d, 32'h0);
    wb_xfer(1'b1, BASE + 32'h1C, 32'hF, d);
    wb_xfer(1'b0, BASE + 32'hC, 32'h0, d);
    check_val("unmapped_wr_ctrl", d, 32'h0);
    write_ctrl(32'hFFFF_FFFF);
    wb_xfer(1'b0, BASE + 32'hC, 32'h0, d);
    check_val("ctrl_rb", d, 32'(m_ctrl));
    write_ctrl(32'h0);

`ifdef UART_WB_CTRL_ECHO_EN
    // Echo: a received character is queued for transmit as well.
    write_ctrl(32'h8);
    rx_send(8'h5A, 1'b0);
    wait_tx_idle();
    check_val("echo_start_count", 32'(starts), 32'd20);
    rx_read("echo_rx");
    write_ctrl(32'h0);
`endif

    // Randomised RX-side traffic against the model.
    for (int it = 0; it < 300; it++) begin
      int op;
      op = $urandom_range(0, 99);
      if (op < 40) rx_send(8'($urandom_range(0, 255)), ($urandom_range(0, 9) == 0));
      else if (op < 75) rx_read("rnd_rx");
      else if (op < 85) check_stat("rnd_stat");
      else if (op < 92) write_stat(32'($urandom_range(0, 7)) << 4);
      else write_ctrl(32'($urandom_range(0, 7)));
      check_val("rnd_irq", 32'(o_irq), model_irq());
    end

    // Asynchronous reset mid-operation.
    write_ctrl(32'h1);
    rx_send(8'hA5, 1'b0);
    rx_send(8'h3C, 1'b0);
    check_val("pre_rst_irq", 32'(o_irq), 32'd1);
    #3 rst_n = 1'b0;
    #1 check_val("async_rst_irq", 32'(o_irq), 32'd0);
    rx_q.delete(); tx_q.delete(); m_sticky = 3'b000; m_ctrl = 4'h0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_stat("stat_after_rst");
    wb_xfer(1'b0, BASE + 32'hC, 32'h0, d);
    check_val("ctrl_after_rst", d, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
